llc_bus_txn_controller: RTL and testbench

- Sequences every bus transaction the last-level cache issues (READ, WRITE, INVALIDATE, RWIM) onto the shared system bus.
- Requests bus ownership from the external bus arbiter and drives the bus operation and address for one cycle.
- Collects snoop responses over a fixed snoop window and merges them into one result.
- Backs off and retries when another cache reports HITM. Returns the merged snoop result and the MESI fill state to the LLC control logic.

---
 rtl/cache_define.sv | 74 +++++++
 rtl/llc_snoop_window.sv | 51 +++++
 rtl/llc_bus_txn_controller.sv | 157 +++++++++++++++
 tb/tb_llc_bus_txn_controller.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_define.sv
// Shared bus/snoop/MESI encodings and the helper functions used by the LLC bus
// transaction controller and its snoop window.
package cache_define;

    localparam int ADDRESS_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_NONE       = 3'd0,
        OP_READ       = 3'd1,
        OP_WRITE      = 3'd2,
        OP_INVALIDATE = 3'd3,
        OP_RWIM       = 3'd4
    } bus_op_t;

    typedef enum logic [1:0] {
        SNP_NOHIT = 2'd0,
        SNP_HIT   = 2'd1,
        SNP_HITM  = 2'd2
    } snoop_t;

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } mesi_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARB     = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_SNOOP   = 3'd3,
        ST_BACKOFF = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    function automatic logic op_legal(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd4);
    endfunction

    // The unused encoding 3 carries no ownership information, so it ranks as NOHIT.
    function automatic snoop_t norm_snoop(input logic [1:0] s);
        return (s == 2'd3) ? SNP_NOHIT : snoop_t'(s);
    endfunction

    function automatic snoop_t merge_snoop(input logic [1:0] a, input logic [1:0] b);
        snoop_t na;
        snoop_t nb;
        na = norm_snoop(a);
        nb = norm_snoop(b);
        return (nb > na) ? nb : na;
    endfunction

    function automatic mesi_t fill_state(input logic [2:0] op, input snoop_t snoop,
                                         input logic exhausted);
        mesi_t m;
        m = MESI_I;
        case (op)
            OP_READ: begin
                if (exhausted)
                    m = MESI_I;
                else if (snoop == SNP_HIT)
                    m = MESI_S;
                else
                    m = MESI_E;
            end
            OP_RWIM:       m = exhausted ? MESI_I : MESI_M;
            OP_INVALIDATE: m = MESI_M;
            default:       m = MESI_I;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/llc_snoop_window.sv
// Snoop window: counts the cycles the window stays open and priority-merges
// every snoop response seen while it is open.
module llc_snoop_window #(
    parameter int SNOOP_WAIT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic       en_i,
    input  logic       snoop_valid_i,
    input  logic [1:0] snoop_result_i,
    output logic       done_o,
    output logic [1:0] result_o,
    output logic [1:0] result_nxt_o
);
    import cache_define::*;

    logic [3:0] cnt_q, cnt_d;
    snoop_t     acc_q, acc_d;

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (load_i) begin
            cnt_d = 4'(SNOOP_WAIT);
            acc_d = SNP_NOHIT;
        end else if (en_i) begin
            if (cnt_q != 4'd0)
                cnt_d = cnt_q - 4'd1;
            if (snoop_valid_i)
                acc_d = merge_snoop(acc_q, snoop_result_i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    always_ff @(posedge clk) begin
        acc_q <= acc_d;
    end

    // done marks the last open cycle; result_nxt already folds in that cycle's response.
    assign done_o       = en_i && (cnt_q == 4'd1);
    assign result_o     = acc_q;
    assign result_nxt_o = acc_d;

endmodule

// File: rtl/llc_bus_txn_controller.sv
// LLC bus transaction controller: arbitrates for the system bus, issues one
// operation, merges the snoop window and retries after HITM with a backoff.
module llc_bus_txn_controller #(
    parameter int ADDRESS_WIDTH = cache_define::ADDRESS_WIDTH,
    parameter int SNOOP_WAIT    = 3,
    parameter int BACKOFF       = 4,
    parameter int MAX_RETRY     = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [2:0]               req_op,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    output logic                     bus_req,
    input  logic                     bus_gnt,
    output logic                     bus_valid,
    output logic [2:0]               bus_op,
    output logic [ADDRESS_WIDTH-1:0] bus_addr,
    input  logic                     snoop_valid,
    input  logic [1:0]               snoop_result,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [1:0]               resp_snoop,
    output logic [1:0]               resp_mesi,
    output logic [1:0]               resp_retries,
    output logic                     busy
);
    import cache_define::*;

    localparam logic [1:0] MAX_RETRY_C = 2'(MAX_RETRY);
    localparam logic [3:0] BACKOFF_C   = 4'(BACKOFF);

    state_t                   state_q, state_d;
    logic [2:0]               op_q, op_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]               retries_q, retries_d;
    logic [3:0]               bo_q, bo_d;

    logic       win_load, win_en, win_done;
    logic [1:0] win_result, win_result_nxt;
    logic       retry_ok;
    snoop_t     final_snoop;

    llc_snoop_window #(
        .SNOOP_WAIT(SNOOP_WAIT)
    ) u_window (
        .clk            (clk),
        .reset          (reset),
        .load_i         (win_load),
        .en_i           (win_en),
        .snoop_valid_i  (snoop_valid),
        .snoop_result_i (snoop_result),
        .done_o         (win_done),
        .result_o       (win_result),
        .result_nxt_o   (win_result_nxt)
    );

    // Only reads want the line badly enough to retry; HITM on a write or
    // invalidate is final because the owner flushes on its own.
    assign retry_ok = (win_result_nxt == SNP_HITM)
                   && ((op_q == OP_READ) || (op_q == OP_RWIM))
                   && (retries_q < MAX_RETRY_C);

    assign final_snoop = op_legal(op_q) ? norm_snoop(win_result) : SNP_NOHIT;

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        retries_d    = retries_q;
        bo_d         = bo_q;
        win_load     = 1'b0;
        win_en       = 1'b0;
        bus_req      = 1'b0;
        bus_valid    = 1'b0;
        bus_op       = '0;
        bus_addr     = '0;
        resp_valid   = 1'b0;
        resp_snoop   = '0;
        resp_mesi    = '0;
        resp_retries = '0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d      = req_op;
                    addr_d    = req_addr;
                    retries_d = '0;
                    state_d   = op_legal(req_op) ? ST_ARB : ST_DONE;
                end
            end
            ST_ARB: begin
                bus_req = 1'b1;
                if (bus_gnt)
                    state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                bus_valid = 1'b1;
                bus_op    = op_q;
                bus_addr  = addr_q;
                win_load  = 1'b1;
                state_d   = ST_SNOOP;
            end
            ST_SNOOP: begin
                win_en = 1'b1;
                if (win_done) begin
                    if (retry_ok) begin
                        retries_d = retries_q + 2'd1;
                        bo_d      = BACKOFF_C;
                        state_d   = ST_BACKOFF;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_BACKOFF: begin
                if (bo_q <= 4'd1)
                    state_d = ST_ARB;
                else
                    bo_d = bo_q - 4'd1;
            end
            ST_DONE: begin
                resp_valid   = 1'b1;
                resp_snoop   = final_snoop;
                resp_mesi    = fill_state(op_q, final_snoop, final_snoop == SNP_HITM);
                resp_retries = retries_q;
                if (resp_ready) begin
                    retries_d = '0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            retries_q <= '0;
            bo_q      <= '0;
        end else begin
            state_q   <= state_d;
            retries_q <= retries_d;
            bo_q      <= bo_d;
        end
    end

    always_ff @(posedge clk) begin
        op_q   <= op_d;
        addr_q <= addr_d;
    end

endmodule

// File: tb/tb_llc_bus_txn_controller.sv
// Directed bench for llc_bus_txn_controller with hand-computed expectations.
module tb_llc_bus_txn_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic        bus_req;
    logic        bus_gnt;
    logic        bus_valid;
    logic [2:0]  bus_op;
    logic [31:0] bus_addr;
    logic        snoop_valid;
    logic [1:0]  snoop_result;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_snoop;
    logic [1:0]  resp_mesi;
    logic [1:0]  resp_retries;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;

    int   r_bv, r_req, r_gap, r_lat, r_bad, r_unstable;
    logic [1:0] r_snoop, r_mesi, r_ret;
    logic r_done;
    logic [3:0][2:0][2:0] pat;

    always #5 clk = ~clk;

    llc_bus_txn_controller dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .bus_req      (bus_req),
        .bus_gnt      (bus_gnt),
        .bus_valid    (bus_valid),
        .bus_op       (bus_op),
        .bus_addr     (bus_addr),
        .snoop_valid  (snoop_valid),
        .snoop_result (snoop_result),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_snoop   (resp_snoop),
        .resp_mesi    (resp_mesi),
        .resp_retries (resp_retries),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one transaction, driving grant and snoop responses from the observed
    // bus activity; pat[window][cycle] = {valid, result}.
    task automatic run_txn(input logic [2:0] op, input logic [31:0] addr,
                           input int gnt_delay, input logic gnt_idle,
                           input int ready_delay, input logic issue_hitm,
                           input logic [3:0][2:0][2:0] p);
        int cyc, sw, w, arb, rcnt, last_bv, k;
        r_bv = 0; r_req = 0; r_gap = -1; r_lat = -1; r_bad = 0; r_unstable = 0;
        r_done = 1'b0; r_snoop = '0; r_mesi = '0; r_ret = '0;
        sw = 0; w = -1; arb = 0; rcnt = 0; last_bv = -1; cyc = 0;
        req_op = op; req_addr = addr; req_valid = 1'b1; bus_gnt = gnt_idle;
        while (!r_done && cyc < 300) begin
            step();
            cyc++;
            req_valid = 1'b0; snoop_valid = 1'b0; snoop_result = '0;
            resp_ready = 1'b0; bus_gnt = gnt_idle;
            if (sw > 0) begin
                k = 3 - sw;
                snoop_valid  = p[w][k][2];
                snoop_result = p[w][k][1:0];
                sw--;
            end
            if (bus_req) begin
                r_req++;
                bus_gnt = (arb >= gnt_delay);
                arb++;
            end else begin
                arb = 0;
            end
            if (bus_valid) begin
                r_bv++;
                if (w < 3) w++;
                sw = 3;
                if (bus_op !== op || bus_addr !== addr) r_bad++;
                if (last_bv >= 0) r_gap = cyc - last_bv;
                last_bv = cyc;
                if (issue_hitm) begin
                    snoop_valid  = 1'b1;
                    snoop_result = 2'd2;
                end
            end
            if (resp_valid) begin
                if (rcnt == 0) begin
                    r_lat = cyc; r_snoop = resp_snoop; r_mesi = resp_mesi; r_ret = resp_retries;
                end else if (resp_snoop !== r_snoop || resp_mesi !== r_mesi || resp_retries !== r_ret) begin
                    r_unstable++;
                end
                if (rcnt >= ready_delay) begin
                    resp_ready = 1'b1;
                    r_done = 1'b1;
                end
                rcnt++;
            end
        end
        step();
        resp_ready = 1'b0; bus_gnt = 1'b0; snoop_valid = 1'b0; snoop_result = '0;
    endtask

    // Starts a READ with HITM on every window and resets it mid-flight:
    // which=0 in the second snoop window, which=1 in a DONE stalled by resp_ready=0.
    task automatic reset_mid(input int which, input string tag);
        int bv;
        logic hit;
        bv = 0; hit = 1'b0;
        req_op = 3'd1; req_addr = 32'h0000_7700; req_valid = 1'b1;
        bus_gnt = 1'b1; snoop_valid = 1'b1; snoop_result = 2'd2; resp_ready = 1'b0;
        for (int n = 0; n < 200 && !hit; n++) begin
            step();
            req_valid = 1'b0;
            if (bus_valid) bv++;
            if (which == 0 && bv == 2 && !bus_valid) hit = 1'b1;
            if (which == 1 && resp_valid) hit = 1'b1;
        end
        chk({tag, "_reached"}, 32'(hit), 32'd1);
        if (which == 1) begin
            step();
            step();
            chk({tag, "_stalled"}, 32'(resp_valid), 32'd1);
        end
        chk({tag, "_busy_pre"}, 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_outs"}, 32'({bus_req, bus_valid, resp_valid, busy, bus_op,
                                 resp_snoop, resp_mesi, resp_retries}), 32'd0);
        chk({tag, "_bus_addr"}, bus_addr, 32'd0);
        reset = 1'b0; bus_gnt = 1'b0; snoop_valid = 1'b0; snoop_result = '0;
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; bus_gnt = 1'b0;
        snoop_valid = 1'b0; snoop_result = '0; resp_ready = 1'b0;
        step(); step(); step();
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_outs", 32'({bus_req, bus_valid, resp_valid, busy, bus_op,
                               resp_snoop, resp_mesi, resp_retries}), 32'd0);
        reset = 1'b0;
        step();

        // READ, grant after 2 ARB cycles, no snoop responses
        pat = '0;
        run_txn(3'd1, 32'h0000_1A40, 2, 1'b0, 0, 1'b0, pat);
        chk("t1_done", 32'(r_done), 32'd1);
        chk("t1_bus_valid_pulses", r_bv, 1);
        chk("t1_bus_op_addr_bad", r_bad, 0);
        chk("t1_bus_req_cycles", r_req, 3);
        chk("t1_latency", r_lat, 8);
        chk("t1_snoop", 32'(r_snoop), 32'd0);
        chk("t1_mesi", 32'(r_mesi), 32'd2);
        chk("t1_retries", 32'(r_ret), 32'd0);

        // READ: HITM in ISSUE cycle ignored; HIT, NOHIT, encoding 3 in window
        pat = '0;
        pat[0][0] = 3'b101; pat[0][1] = 3'b100; pat[0][2] = 3'b111;
        run_txn(3'd1, 32'h0000_2000, 0, 1'b0, 0, 1'b1, pat);
        chk("t2_bus_valid_pulses", r_bv, 1);
        chk("t2_latency", r_lat, 6);
        chk("t2_snoop", 32'(r_snoop), 32'd1);
        chk("t2_mesi", 32'(r_mesi), 32'd1);

        // RWIM: HITM then NOHIT, grant held high outside ARB
        pat = '0;
        pat[0][1] = 3'b110; pat[1][0] = 3'b100;
        run_txn(3'd4, 32'h0000_3000, 0, 1'b1, 0, 1'b0, pat);
        chk("t3_bus_valid_pulses", r_bv, 2);
        chk("t3_issue_gap", r_gap, 9);
        chk("t3_bus_req_cycles", r_req, 2);
        chk("t3_latency", r_lat, 15);
        chk("t3_snoop", 32'(r_snoop), 32'd0);
        chk("t3_mesi", 32'(r_mesi), 32'd3);
        chk("t3_retries", 32'(r_ret), 32'd1);

        // READ: HITM on the last cycle of every window, response stalled 3 cycles
        pat = '0;
        for (int i = 0; i < 4; i++) pat[i][2] = 3'b110;
        run_txn(3'd1, 32'h0000_4000, 0, 1'b0, 3, 1'b0, pat);
        chk("t4_bus_valid_pulses", r_bv, 4);
        chk("t4_latency", r_lat, 33);
        chk("t4_snoop", 32'(r_snoop), 32'd2);
        chk("t4_mesi", 32'(r_mesi), 32'd0);
        chk("t4_retries", 32'(r_ret), 32'd3);
        chk("t4_resp_stable", r_unstable, 0);

        // INVALIDATE with HITM: no retry
        pat = '0;
        pat[0][0] = 3'b110;
        run_txn(3'd3, 32'h0000_5000, 0, 1'b0, 0, 1'b0, pat);
        chk("t5_bus_valid_pulses", r_bv, 1);
        chk("t5_snoop", 32'(r_snoop), 32'd2);
        chk("t5_mesi", 32'(r_mesi), 32'd3);
        chk("t5_retries", 32'(r_ret), 32'd0);

        // WRITE with HIT: line evicted
        pat = '0;
        pat[0][1] = 3'b101;
        run_txn(3'd2, 32'h0000_6000, 1, 1'b0, 0, 1'b0, pat);
        chk("t6_bus_req_cycles", r_req, 2);
        chk("t6_snoop", 32'(r_snoop), 32'd1);
        chk("t6_mesi", 32'(r_mesi), 32'd0);

        // Illegal op 6: straight to DONE, grant high but no bus activity
        pat = '0;
        run_txn(3'd6, 32'h0000_6600, 0, 1'b1, 0, 1'b0, pat);
        chk("t7_bus_req_cycles", r_req, 0);
        chk("t7_bus_valid_pulses", r_bv, 0);
        chk("t7_latency", r_lat, 1);
        chk("t7_resp", 32'({r_snoop, r_mesi, r_ret}), 32'd0);

        // Reset during SNOOP, then a clean READ
        reset_mid(0, "rst_snoop");
        pat = '0;
        run_txn(3'd1, 32'h0000_8000, 0, 1'b0, 0, 1'b0, pat);
        chk("t8_latency", r_lat, 6);
        chk("t8_mesi", 32'(r_mesi), 32'd2);
        chk("t8_retries", 32'(r_ret), 32'd0);

        // Reset during a stalled DONE, then a clean READ
        reset_mid(1, "rst_done");
        pat = '0;
        pat[0][0] = 3'b101;
        run_txn(3'd1, 32'h0000_9000, 0, 1'b0, 0, 1'b0, pat);
        chk("t9_bus_valid_pulses", r_bv, 1);
        chk("t9_snoop", 32'(r_snoop), 32'd1);
        chk("t9_mesi", 32'(r_mesi), 32'd1);
        chk("t9_retries", 32'(r_ret), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
